// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared tag encoding and defaults for the text ROM arbiter
package rom_arb_pkg;

  typedef enum logic [1:0] {
    TAG_NONE = 2'b00,
    TAG_F    = 2'b01,
    TAG_D    = 2'b10
  } rom_tag_e;

  localparam int DEFAULT_STARVE_LIMIT = 8;

endpackage

// File: rtl/rom_arb_resp.sv
// rtl/rom_arb_resp.sv - response tag register, fetch flush gating and per-port rdata hold
module rom_arb_resp
  import rom_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  f_gnt_i,
  input  logic                  d_gnt_i,
  input  logic                  f_flush_i,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic                  f_rvalid_o,
  output logic [DATA_WIDTH-1:0] f_rdata_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o
);

  rom_tag_e              tag_q, tag_d;
  logic [DATA_WIDTH-1:0] f_hold_q, f_hold_d;
  logic [DATA_WIDTH-1:0] d_hold_q, d_hold_d;

  // A flush kills both the fetch response arriving now and a fetch granted now.
  always_comb begin
    tag_d = TAG_NONE;
    if (d_gnt_i)                 tag_d = TAG_D;
    else if (f_gnt_i && !f_flush_i) tag_d = TAG_F;
  end

  assign f_rvalid_o = (tag_q == TAG_F) && !f_flush_i;
  assign d_rvalid_o = (tag_q == TAG_D);

  always_comb begin
    f_hold_d = f_hold_q;
    d_hold_d = d_hold_q;
    if (f_rvalid_o) f_hold_d = rom_data_i;
    if (d_rvalid_o) d_hold_d = rom_data_i;
  end

  assign f_rdata_o = f_hold_d;
  assign d_rdata_o = d_hold_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q    <= TAG_NONE;
      f_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      tag_q    <= tag_d;
      f_hold_q <= f_hold_d;
      d_hold_q <= d_hold_d;
    end
  end

endmodule

// File: rtl/rom_text_arbiter.sv
// rtl/rom_text_arbiter.sv - shares the text ROM read port between fetch and debug; ROM_ARB_RR_EN selects round-robin
module rom_text_arbiter
  import rom_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 15,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
  parameter int CNT_WIDTH    = 4
) (
  input  logic                  rawclk,
  input  logic                  rst_n,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  input  logic                  f_flush,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [DATA_WIDTH-1:0] f_rdata,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data
);

  logic                  f_act, d_act;
  logic                  f_win, d_win;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  // Requests are ignored while reset is held so no grant leaks out.
  assign f_act = f_req & rst_n;
  assign d_act = d_req & rst_n;

`ifdef ROM_ARB_RR_EN
  logic last_d_q, last_d_d;

  always_comb begin
    f_win    = 1'b0;
    d_win    = 1'b0;
    last_d_d = last_d_q;
    if (f_act && d_act) begin
      if (last_d_q) f_win = 1'b1;
      else          d_win = 1'b1;
      last_d_d = ~last_d_q;
    end else if (f_act) begin
      f_win = 1'b1;
    end else if (d_act) begin
      d_win = 1'b1;
    end
  end

  // Starting as if D was last served gives F the first contested grant.
  always_ff @(posedge rawclk or negedge rst_n) begin
    if (!rst_n) last_d_q <= 1'b1;
    else        last_d_q <= last_d_d;
  end
`else
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    f_win = 1'b0;
    d_win = 1'b0;
    cnt_d = cnt_q;
    if (f_act && d_act) begin
      if (cnt_q == CNT_WIDTH'(STARVE_LIMIT)) begin
        d_win = 1'b1;
      end else begin
        f_win = 1'b1;
        cnt_d = cnt_q + 1'b1;
      end
    end else if (f_act) begin
      f_win = 1'b1;
    end else if (d_act) begin
      d_win = 1'b1;
    end
    if (d_win) cnt_d = '0;
  end

  always_ff @(posedge rawclk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign f_gnt = f_win;
  assign d_gnt = d_win;

  always_comb begin
    addr_d = addr_q;
    if (f_win)      addr_d = f_addr;
    else if (d_win) addr_d = d_addr;
  end

  assign rom_addr = addr_d;

  always_ff @(posedge rawclk or negedge rst_n) begin
    if (!rst_n) addr_q <= '0;
    else        addr_q <= addr_d;
  end

  rom_arb_resp #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_resp (
    .clk_i     (rawclk),
    .rst_ni    (rst_n),
    .f_gnt_i   (f_win),
    .d_gnt_i   (d_win),
    .f_flush_i (f_flush),
    .rom_data_i(rom_data),
    .f_rvalid_o(f_rvalid),
    .f_rdata_o (f_rdata),
    .d_rvalid_o(d_rvalid),
    .d_rdata_o (d_rdata)
  );

endmodule

// File: doc/rom_text_arbiter.md
Name: rom_text_arbiter

Overview:
- Shares the single-read-port instruction block ROM between two requesters: pipeline fetch (port F) and debug/monitor reader (port D).
- The ROM is synchronous: address presented in cycle N yields data in cycle N+1.
- The block arbitrates each cycle, drives the ROM address, and tags the returning data back to the winning requester.
- It sits between the IF stage, the debug/display path, and the text ROM.

Parameters:
- DATA_WIDTH, 32, ROM word width.
- ADDR_WIDTH, 15, word address width seen by requesters and ROM.
- STARVE_LIMIT, 8, consecutive cycles D may be denied before it is forced a grant (≥1).
- CNT_WIDTH, 4, width of starvation counter (must hold STARVE_LIMIT).

Ports:
- rawclk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- f_req  in  1  fetch read request.
- f_addr  in  ADDR_WIDTH  fetch word address.
- f_flush  in  1  discard any in-flight fetch response.
- f_gnt  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  fetch data valid.
- f_rdata  out  DATA_WIDTH  fetch data.
- d_req  in  1  debug read request.
- d_addr  in  ADDR_WIDTH  debug word address.
- d_gnt  out  1  debug request accepted this cycle.
- d_rvalid  out  1  debug data valid.
- d_rdata  out  DATA_WIDTH  debug data.
- rom_addr  out  ADDR_WIDTH  address to ROM.
- rom_data  in  DATA_WIDTH  ROM read data (1-cycle latency).

Behaviour:
- Reset (async, rst_n=0): starvation counter=0, response tag=NONE, f_rvalid=d_rvalid=0, rom_addr register=0.
- Gnt outputs are combinational from req and state, and are 0 while rst_n=0.
- Grant rules, fixed priority with starvation escape:
  - Only f_req → F wins.
  - Only d_req → D wins.
  - Both requesting and counter<STARVE_LIMIT → F wins; counter increments.
  - Both requesting and counter==STARVE_LIMIT → D wins.
  - Whenever D wins, the counter clears to 0. It holds when d_req=0.
  - Neither requesting → no grant; rom_addr holds its last value.
- At most one gnt is high per cycle. gnt implies the request is consumed; no request is held inside the block.
- rom_addr is combinational mux of the winner's address (previous value held when idle). The ROM registers it internally.
- Response tag register captures {F, D, NONE} at the grant edge.
- Next cycle: the tagged port's rvalid=1 and its rdata=rom_data. The other port's rvalid=0, and its rdata holds its last valid value (stored per-port register).
- Latency: request in cycle N, rvalid/rdata in N+1. Back-to-back grants give one response per cycle.
- f_flush=1 in cycle N clears an F tag captured at edge N, and also a grant issued in N. No f_rvalid appears for them. D responses are never affected.
- Simultaneous flush and new f_req in the same cycle: the request is still granted but its response is suppressed. The IF stage re-requests next cycle.
- Reset asserted mid-transfer: pending tag is dropped, no rvalid after release.

Optional Feature:
- Macro ROM_ARB_RR_EN.
- Defined: pure round-robin arbitration. Last-winner bit flips on each contested grant; on contest, the port not last served wins. The starvation counter and STARVE_LIMIT are unused.
- Undefined: fixed priority with starvation escape as above.

Decomposition:
- Shared package rom_arb_pkg holds:
  - Tag encoding constants: TAG_NONE=2'b00, TAG_F=2'b01, TAG_D=2'b10.
  - Default STARVE_LIMIT.
- One natural sub-module, rom_arb_resp: tag register, flush gating, per-port rdata hold registers. The top keeps grant logic and counter.

Test Plan:
- Only f_req with f_addr=0x0004 → f_gnt=1 same cycle, rom_addr=0x0004; next cycle f_rvalid=1, f_rdata=ROM[4], d_rvalid=0.
- f_req and d_req held high continuously, STARVE_LIMIT=8 → F granted 8 cycles, D granted on the 9th, then F for 8 more. d_rvalid exactly one cycle after each d_gnt.
- F granted at addr 0x0010 with f_flush=1 the following cycle → f_rvalid stays 0; a D grant in that flush cycle still returns d_rvalid=1 with ROM[d_addr].
- Alternate single requests F@0x1, D@0x2, F@0x3 on consecutive cycles → responses on the next three cycles, correctly steered. d_rdata holds ROM[2] while F responses arrive.
- Drop rst_n low the cycle after a D grant → d_rvalid=0 throughout reset; no spurious rvalid after release; counter=0.
- With ROM_ARB_RR_EN defined and both requesting → grants alternate F, D, F, D from reset.
